load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory stage of the RV32I pipeline, directly downstream of the execute-stage ALU. It takes the ALU result as the effective address or as a pass-through value, and runs a request/acknowledge transaction with data memory. It aligns store data and byte enables, and sign- or zero-extends load data. It stalls upstream while a transaction is outstanding and produces the registered writeback value.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: address width; `dmem_addr` is word-aligned (bits [1:0] = 0).
- `DATA_WIDTH`, 32: data path width; only 32 is supported.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ex_valid` in 1: execute stage presents an instruction.
- `ex_mem_read` in 1: the instruction is a load.
- `ex_mem_write` in 1: the instruction is a store.
- `ex_reg_write` in 1: the instruction writes `rd`.
- `ex_funct3` in 3: load/store size/sign encoding (RV32I).
- `ex_rd` in 5: destination register.
- `ex_alu_result` in 32: ALU result; the effective address for memory ops.
- `ex_store_data` in 32: rs2 value for stores.
- `lsu_stall` out 1: hold the execute stage.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: request is a write.
- `dmem_addr` out 32: word address.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-aligned write data.
- `dmem_ack` in 1: request completes this cycle; meaningful only while `dmem_req`=1.
- `dmem_rdata` in 32: read word, valid with `dmem_ack`.
- `wb_valid` out 1: one-cycle pulse, writeback slot valid.
- `wb_reg_write` out 1: the writeback slot writes `wb_rd`.
- `wb_rd` out 5: writeback destination register.
- `wb_data` out 32: writeback value.
- `lsu_fault` out 1: one-cycle pulse for a misaligned or illegal access.

## Operation
- FSM states:
  - `IDLE`: no outstanding transaction.
  - `BUSY`: `dmem_req` held high.
- Accept condition: `ex_valid && !lsu_stall`.
- Non-memory op (`ex_mem_read`=`ex_mem_write`=0):
  - Next cycle: `wb_valid`=1, `wb_data`=`ex_alu_result`, `wb_reg_write`=`ex_reg_write`.
  - State stays `IDLE`.
- Legal memory op:
  - Capture address, size, rd, aligned wdata and byte enables; go to `BUSY`.
  - In `BUSY`, `dmem_req`/`dmem_we`/`dmem_addr`/`dmem_be`/`dmem_wdata` stay constant until the edge where `dmem_ack`=1.
- Fault: any of the following produces no request; next cycle `lsu_fault`=1, `wb_valid`=1, `wb_reg_write`=0.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Load funct3 ∈ {3,6,7}.
  - Store funct3 > 2.
  - `ex_mem_read` and `ex_mem_write` both high.
- Store lanes:
  - SB: `dmem_be`=4'b0001<<addr[1:0]; wdata byte replicated to all four lanes.
  - SH: `dmem_be`=4'b0011<<addr[1:0]; halfword replicated to both halves.
  - SW: `dmem_be`=4'b1111.
  - For loads, `dmem_be` is driven with the same pattern as the equivalent-size store.
- Load extract: select the byte/halfword of `dmem_rdata` by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Completion: at the ack edge, `wb_data` = extracted load value (store: 0), `wb_reg_write` = captured `ex_reg_write` (stores: 0), `wb_valid` pulses the next cycle.
- Back-to-back: a new op offered in the ack cycle is accepted at the same edge. A new memory op goes straight back to `BUSY`, otherwise the state returns to `IDLE`.

## Timing
- Reset value of every output is 0. The FSM resets to `IDLE`.
- Reset while `BUSY`: `dmem_req`=0 the following cycle; the transaction is abandoned and a later ack is ignored.
- `lsu_stall` = (`BUSY` && !`dmem_ack`), combinational.
- Latency, memory op accepted at edge T:
  - `dmem_req`=1 from cycle T+1.
  - Ack in cycle T+1+k (k≥0 wait states) → `wb_valid` in cycle T+2+k.
  - Zero-wait memory therefore gives a 2-cycle load-to-writeback latency.
- Non-memory op and fault: `wb_valid` 1 cycle after acceptance; no stall.
- `dmem_ack` while `IDLE` is ignored.
- `wb_*` and `lsu_fault` are registered; `wb_valid` is never high two cycles for one instruction.

## Structure
- Package `common` gains:
  - funct3 constants `LSU_LB`, `LSU_LH`, `LSU_LW`, `LSU_LBU`, `LSU_LHU`, `LSU_SB`, `LSU_SH`, `LSU_SW`.
  - `lsu_state_t` enum {`LSU_IDLE`, `LSU_BUSY`}.
- Sub-module `lsu_align`, purely combinational:
  - Store side: `dmem_be`/`dmem_wdata` generation from size and addr[1:0].
  - Load side: extraction and sign extension.
  - Instantiated once for the store side and once for the load side, or a single instance with both functions.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, ack after 2 wait cycles:
  - `dmem_req` held 3 cycles, addr 0x100, be 4'b1111.
  - `lsu_stall` high 2 cycles.
  - `wb_valid` with `wb_reg_write`=0.
- LB addr 0x103, rdata 0x80FF_0000, zero-wait → `wb_data` 0xFFFFFF80.
- LBU at the same address → `wb_data` 0x00000080.
- SH addr 0x202, data 0x0000_1234 → be 4'b1100, wdata 0x12341234.
- LW addr 0x101 → no `dmem_req`; `lsu_fault` and `wb_valid` pulse 1 cycle later; `wb_reg_write`=0.
- Back-to-back:
  - LW then ADD (`ex_alu_result` 0x55), zero-wait → ADD accepted on the ack edge and its `wb_valid` arrives the cycle after the LW's.
  - Reset asserted mid-`BUSY` → `dmem_req` drops next cycle and all outputs are 0.

Source files
------------

// File: rtl/common.sv
// Shared RV32I memory-stage definitions: load/store funct3 encodings and the
// load/store unit FSM state type.
package common;

  localparam logic [2:0] LSU_LB  = 3'd0;
  localparam logic [2:0] LSU_LH  = 3'd1;
  localparam logic [2:0] LSU_LW  = 3'd2;
  localparam logic [2:0] LSU_LBU = 3'd4;
  localparam logic [2:0] LSU_LHU = 3'd5;
  localparam logic [2:0] LSU_SB  = 3'd0;
  localparam logic [2:0] LSU_SH  = 3'd1;
  localparam logic [2:0] LSU_SW  = 3'd2;

  typedef enum logic [0:0] {
    LSU_IDLE = 1'b0,
    LSU_BUSY = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables and replicated write data,
// plus load byte/halfword extraction with sign or zero extension.
module lsu_align
  import common::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_value
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Loads reuse the store pattern, so only the size bits matter here.
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = st_data;
    case (st_funct3[1:0])
      2'd0: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      2'd1: begin
        st_be    = 4'b0011 << st_off;
        st_wdata = {2{st_data[15:0]}};
      end
      2'd2:    st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  always_comb begin
    ld_byte  = ld_rdata[{ld_off, 3'b000} +: 8];
    ld_half  = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_value = '0;
    case (ld_funct3)
      LSU_LB:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      LSU_LH:  ld_value = {{16{ld_half[15]}}, ld_half};
      LSU_LW:  ld_value = ld_rdata;
      LSU_LBU: ld_value = {24'd0, ld_byte};
      LSU_LHU: ld_value = {16'd0, ld_half};
      default: ld_value = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: runs one req/ack data-memory transaction at a time,
// stalls execute while waiting, and registers the writeback slot.
module load_store_unit
  import common::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_reg_write,
  input  logic [2:0]            ex_funct3,
  input  logic [4:0]            ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_store_data,
  output logic                  lsu_stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  lsu_fault
);

  lsu_state_t state;

  logic [2:0]            funct3_p1;
  logic [1:0]            off_p1;
  logic [4:0]            rd_p1;
  logic                  regw_p1;

  logic                  vld_p2;
  logic [DATA_WIDTH-1:0] data_p2;
  logic                  regw_p2;
  logic [4:0]            rd_p2;
  logic                  fault_p2;

  logic                  busy, done, accept, is_mem, misal, bad_op, fault, defer;
  logic [3:0]            st_be;
  logic [31:0]           st_wdata, ld_value;

  lsu_align u_align (
    .st_funct3 (ex_funct3),
    .st_off    (ex_alu_result[1:0]),
    .st_data   (ex_store_data),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_funct3 (funct3_p1),
    .ld_off    (off_p1),
    .ld_rdata  (dmem_rdata),
    .ld_value  (ld_value)
  );

  assign busy      = (state == LSU_BUSY);
  assign done      = busy && dmem_ack;
  assign lsu_stall = busy && !dmem_ack;
  assign dmem_req  = busy;
  assign accept    = ex_valid && !lsu_stall;
  assign is_mem    = ex_mem_read || ex_mem_write;

  assign misal  = ((ex_funct3[1:0] == 2'd1) && ex_alu_result[0]) ||
                  ((ex_funct3[1:0] == 2'd2) && (ex_alu_result[1:0] != 2'b00));
  assign bad_op = (ex_mem_read && ex_mem_write) ||
                  (ex_mem_read && (ex_funct3 == 3'd3 || ex_funct3[2:1] == 2'b11)) ||
                  (ex_mem_write && (ex_funct3 > 3'd2));
  assign fault  = is_mem && (misal || bad_op);
  // A result finishing on the ack edge (or one already parked) owns the next
  // writeback slot, so a simultaneously accepted ALU/fault result waits a cycle.
  assign defer  = done || vld_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LSU_IDLE;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      funct3_p1    <= '0;
      off_p1       <= '0;
      rd_p1        <= '0;
      regw_p1      <= 1'b0;
      vld_p2       <= 1'b0;
      data_p2      <= '0;
      regw_p2      <= 1'b0;
      rd_p2        <= '0;
      fault_p2     <= 1'b0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      lsu_fault    <= 1'b0;
    end else begin
      wb_valid  <= 1'b0;
      lsu_fault <= 1'b0;
      vld_p2    <= 1'b0;

      // p1 -> writeback: memory completion or parked result
      if (done) begin
        state        <= LSU_IDLE;
        wb_valid     <= 1'b1;
        wb_data      <= dmem_we ? '0 : ld_value;
        wb_reg_write <= !dmem_we && regw_p1;
        wb_rd        <= rd_p1;
      end else if (vld_p2) begin
        wb_valid     <= 1'b1;
        wb_data      <= data_p2;
        wb_reg_write <= regw_p2;
        wb_rd        <= rd_p2;
        lsu_fault    <= fault_p2;
      end

      // execute -> p1 (memory) or writeback/p2 (ALU pass-through, fault)
      if (accept) begin
        if (is_mem && !fault) begin
          state      <= LSU_BUSY;
          dmem_we    <= ex_mem_write;
          dmem_addr  <= {ex_alu_result[ADDR_WIDTH-1:2], 2'b00};
          dmem_be    <= st_be;
          dmem_wdata <= st_wdata;
          funct3_p1  <= ex_funct3;
          off_p1     <= ex_alu_result[1:0];
          rd_p1      <= ex_rd;
          regw_p1    <= ex_reg_write;
        end else if (defer) begin
          vld_p2   <= 1'b1;
          data_p2  <= fault ? '0 : ex_alu_result;
          regw_p2  <= !fault && ex_reg_write;
          rd_p2    <= ex_rd;
          fault_p2 <= fault;
        end else begin
          wb_valid     <= 1'b1;
          wb_data      <= fault ? '0 : ex_alu_result;
          wb_reg_write <= !fault && ex_reg_write;
          wb_rd        <= ex_rd;
          lsu_fault    <= fault;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of single ops with a scripted memory
// responder, a writeback scoreboard, and hand-written multi-cycle sequences.
module tb_load_store_unit;
  import common::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_result, ex_store_data;
  logic        lsu_stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_reg_write, lsu_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_funct3(ex_funct3),
    .ex_rd(ex_rd), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .lsu_stall(lsu_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .lsu_fault(lsu_fault)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check32(input string nm, input logic [31:0] act,
                                  input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endfunction

  function automatic void check1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", nm, act, exp);
    end
  endfunction

  typedef struct {
    logic [31:0] data;
    logic        regw;
    logic [4:0]  rd;
    logic        fault;
  } wb_t;

  wb_t sb_q[$];
  wb_t mon_e;

  // Scoreboard: every writeback pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_wb: got wb_valid=1 data %h, required no writeback", wb_data);
      end else begin
        mon_e = sb_q.pop_front();
        check32("wb_data", wb_data, mon_e.data);
        check1("wb_reg_write", wb_reg_write, mon_e.regw);
        check32("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
        check1("lsu_fault", lsu_fault, mon_e.fault);
      end
    end else if (!reset && lsu_fault) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stray_fault: got lsu_fault=1 with wb_valid=0, required 0");
    end
  end

  typedef struct {
    logic [31:0] alu;
    logic [2:0]  f3;
    logic        rd_en, wr_en, regw;
    logic [4:0]  rd;
    logic [31:0] sdata, rdata;
    int          waits;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] wdata, wbd;
    logic        wbregw;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl[NV];

  task automatic offer(input vec_t v);
    ex_valid      = 1'b1;
    ex_alu_result = v.alu;
    ex_funct3     = v.f3;
    ex_mem_read   = v.rd_en;
    ex_mem_write  = v.wr_en;
    ex_reg_write  = v.regw;
    ex_rd         = v.rd;
    ex_store_data = v.sdata;
  endtask

  task automatic idle_ex();
    ex_valid     = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    ex_reg_write = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    wb_t   e;
    string nm;
    nm = $sformatf("v%0d", idx);
    @(negedge clk);
    offer(v);
    check1({nm, "_stall_at_offer"}, lsu_stall, 1'b0);
    e.data = v.wbd; e.regw = v.wbregw; e.rd = v.rd; e.fault = v.fault;
    sb_q.push_back(e);
    @(posedge clk);
    #1 idle_ex();
    if (v.fault || !(v.rd_en || v.wr_en)) begin
      @(negedge clk);
      check1({nm, "_no_req"}, dmem_req, 1'b0);
      check1({nm, "_wb_valid"}, wb_valid, 1'b1);
      check1({nm, "_no_stall"}, lsu_stall, 1'b0);
    end else begin
      for (int i = 0; i <= v.waits; i++) begin
        @(negedge clk);
        check1({nm, "_req"}, dmem_req, 1'b1);
        check1({nm, "_we"}, dmem_we, v.wr_en);
        check32({nm, "_addr"}, dmem_addr, {v.alu[31:2], 2'b00});
        check32({nm, "_be"}, {28'd0, dmem_be}, {28'd0, v.be});
        if (v.wr_en) check32({nm, "_wdata"}, dmem_wdata, v.wdata);
        check1({nm, "_wb_idle"}, wb_valid, 1'b0);
        if (i == v.waits) begin
          dmem_ack   = 1'b1;
          dmem_rdata = v.rdata;
          #1 check1({nm, "_stall_ack"}, lsu_stall, 1'b0);
        end else begin
          check1({nm, "_stall_wait"}, lsu_stall, 1'b1);
        end
        @(posedge clk);
        #1 dmem_ack = 1'b0;
        dmem_rdata = $urandom;
      end
      @(negedge clk);
      check1({nm, "_wb_valid"}, wb_valid, 1'b1);
      check1({nm, "_req_drop"}, dmem_req, 1'b0);
    end
    @(negedge clk);
    check1({nm, "_wb_pulse"}, wb_valid, 1'b0);
  endtask

  initial begin
    // alu, f3, rd_en, wr_en, regw, rd, sdata, rdata, waits, fault, be, wdata, wbd, wbregw
    tbl[0]  = '{32'h12345678, 3'd0, 1'b0, 1'b0, 1'b1, 5'd3,  32'h0, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h12345678, 1'b1};
    tbl[1]  = '{32'h00000100, 3'd2, 1'b0, 1'b1, 1'b0, 5'd0,  32'hDEADBEEF, 32'h0, 2, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[2]  = '{32'h00000103, 3'd0, 1'b1, 1'b0, 1'b1, 5'd5,  32'h0, 32'h80FF0000, 0, 1'b0, 4'h8, 32'h0, 32'hFFFFFF80, 1'b1};
    tbl[3]  = '{32'h00000103, 3'd4, 1'b1, 1'b0, 1'b1, 5'd6,  32'h0, 32'h80FF0000, 0, 1'b0, 4'h8, 32'h0, 32'h00000080, 1'b1};
    tbl[4]  = '{32'h00000202, 3'd1, 1'b0, 1'b1, 1'b1, 5'd4,  32'h00001234, 32'h0, 1, 1'b0, 4'hC, 32'h12341234, 32'h0, 1'b0};
    tbl[5]  = '{32'h00000101, 3'd2, 1'b1, 1'b0, 1'b1, 5'd7,  32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0};
    tbl[6]  = '{32'h00000102, 3'd1, 1'b1, 1'b0, 1'b1, 5'd8,  32'h0, 32'h80017FFF, 3, 1'b0, 4'hC, 32'h0, 32'hFFFF8001, 1'b1};
    tbl[7]  = '{32'h00000100, 3'd5, 1'b1, 1'b0, 1'b1, 5'd9,  32'h0, 32'h8001F00D, 1, 1'b0, 4'h3, 32'h0, 32'h0000F00D, 1'b1};
    tbl[8]  = '{32'h00000104, 3'd2, 1'b1, 1'b0, 1'b1, 5'd10, 32'h0, 32'hCAFEF00D, 0, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b1};
    tbl[9]  = '{32'h00000101, 3'd0, 1'b0, 1'b1, 1'b0, 5'd0,  32'h123456A5, 32'h0, 0, 1'b0, 4'h2, 32'hA5A5A5A5, 32'h0, 1'b0};
    tbl[10] = '{32'h00000101, 3'd1, 1'b1, 1'b0, 1'b1, 5'd12, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0};
    tbl[11] = '{32'h00000100, 3'd3, 1'b1, 1'b0, 1'b1, 5'd13, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0};
    tbl[12] = '{32'h00000100, 3'd6, 1'b1, 1'b0, 1'b1, 5'd14, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0};
    tbl[13] = '{32'h00000100, 3'd3, 1'b0, 1'b1, 1'b0, 5'd15, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0};
    tbl[14] = '{32'h00000100, 3'd2, 1'b1, 1'b1, 1'b1, 5'd16, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0};
    tbl[15] = '{32'h00000101, 3'd0, 1'b1, 1'b0, 1'b1, 5'd17, 32'h0, 32'h00007F00, 0, 1'b0, 4'h2, 32'h0, 32'h0000007F, 1'b1};
    tbl[16] = '{32'hFFFFFFFF, 3'd0, 1'b0, 1'b0, 1'b0, 5'd11, 32'h0, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'hFFFFFFFF, 1'b0};
    tbl[17] = '{32'h00000200, 3'd1, 1'b0, 1'b1, 1'b0, 5'd18, 32'hFFFFABCD, 32'h0, 0, 1'b0, 4'h3, 32'hABCDABCD, 32'h0, 1'b0};

    reset = 1'b1;
    idle_ex();
    ex_funct3 = 3'd0; ex_rd = 5'd0; ex_alu_result = 32'h0; ex_store_data = 32'h0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst_req", dmem_req, 1'b0);
    check1("rst_stall", lsu_stall, 1'b0);
    check1("rst_wb_valid", wb_valid, 1'b0);
    check32("rst_wb_data", wb_data, 32'h0);
    check1("rst_fault", lsu_fault, 1'b0);
    check32("rst_addr", dmem_addr, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Stray ack while idle must be ignored.
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h13572468;
    @(posedge clk);
    #1 dmem_ack = 1'b0;
    @(negedge clk);
    check1("idle_ack_wb", wb_valid, 1'b0);
    check1("idle_ack_req", dmem_req, 1'b0);

    for (int i = 0; i < NV; i++) run_vec(tbl[i], i);

    // Back-to-back: LW then ADD offered in the ack cycle.
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_reg_write = 1'b1;
    ex_funct3 = LSU_LW; ex_rd = 5'd20; ex_alu_result = 32'h00000200;
    sb_q.push_back('{32'h11223344, 1'b1, 5'd20, 1'b0});
    @(posedge clk);
    #1 ex_mem_read = 1'b0; ex_rd = 5'd21; ex_alu_result = 32'h00000055;
    dmem_ack = 1'b1; dmem_rdata = 32'h11223344;
    sb_q.push_back('{32'h00000055, 1'b1, 5'd21, 1'b0});
    @(negedge clk);
    check1("b2b_req", dmem_req, 1'b1);
    check1("b2b_stall", lsu_stall, 1'b0);
    @(posedge clk);
    #1 idle_ex(); dmem_ack = 1'b0;
    @(negedge clk);
    check1("b2b_lw_wb", wb_valid, 1'b1);
    check32("b2b_lw_data", wb_data, 32'h11223344);
    check1("b2b_req_idle", dmem_req, 1'b0);
    @(negedge clk);
    check1("b2b_add_wb", wb_valid, 1'b1);
    check32("b2b_add_data", wb_data, 32'h00000055);
    @(negedge clk);
    check1("b2b_end", wb_valid, 1'b0);

    // Reset while BUSY abandons the transaction.
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
    ex_funct3 = LSU_LW; ex_rd = 5'd22; ex_alu_result = 32'h00000300;
    @(posedge clk);
    #1 idle_ex();
    @(negedge clk);
    check1("rb_req", dmem_req, 1'b1);
    check1("rb_stall", lsu_stall, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check1("rb_req_drop", dmem_req, 1'b0);
    check1("rb_stall_drop", lsu_stall, 1'b0);
    check32("rb_addr", dmem_addr, 32'h0);
    check32("rb_be", {28'd0, dmem_be}, 32'h0);
    check1("rb_wb_valid", wb_valid, 1'b0);
    check32("rb_wb_data", wb_data, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1 dmem_ack = 1'b0;
    @(negedge clk);
    check1("rb_late_ack", wb_valid, 1'b0);
    repeat (2) @(negedge clk);

    check32("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
